// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the multi-channel memory responder.
//   state_t       : per-channel read/write transaction state
//   cnt_bits()    : width of the latency down-counter for a given LATENCY
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Counter holds LATENCY-1 down to 0, so LATENCY+1 distinct values is ample.
  function automatic int cnt_bits(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between a requester (GPU top level or bench) and
// the memory responder.
//   mem_read_*  : per-channel read request / acknowledge with data
//   mem_write_* : per-channel write request / acknowledge
//   load_*      : sideband preload strobe, address and data
//   protocol_error : sticky flag, a requester dropped valid before ready
interface mem_responder_if #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4
);

  logic [NUM_CHANNELS-1:0]                mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]                mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;

  logic [NUM_CHANNELS-1:0]                mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0]                mem_write_ready;

  logic                                   load_valid;
  logic [ADDR_BITS-1:0]                   load_address;
  logic [DATA_BITS-1:0]                   load_data;

  logic                                   protocol_error;

  modport master (
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    output load_valid, load_address, load_data,
    input  mem_read_ready, mem_read_data, mem_write_ready, protocol_error
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    input  load_valid, load_address, load_data,
    output mem_read_ready, mem_read_data, mem_write_ready, protocol_error
  );

endinterface

// File: rtl/mem_channel_fsm.sv
// One read or write transaction sequencer for a single channel.
//   clk, reset  : clock, async active-high reset (control state only)
//   valid_i     : request valid from the requester
//   payload_i   : request payload (address, or {data, address} for writes)
//   ready_o     : acknowledge, held until valid drops
//   commit_o    : one-cycle strobe; the top performs the storage access on
//                 the edge that ends this cycle
//   abort_o     : one-cycle strobe; valid dropped while waiting
//   payload_o   : payload captured when the request was accepted
//
// state   | meaning
// IDLE    | no transaction; accept on valid
// WAIT    | latency countdown; commit when counter reaches 0
// RESPOND | ready held until valid is released
module mem_channel_fsm
  import mem_responder_pkg::*;
#(
  parameter int LATENCY      = 2,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  input  logic [PAYLOAD_BITS-1:0] payload_i,
  output logic                    ready_o,
  output logic                    commit_o,
  output logic                    abort_o,
  output logic [PAYLOAD_BITS-1:0] payload_o
);

  localparam int CNT_BITS = cnt_bits(LATENCY);
  localparam logic [CNT_BITS-1:0] CNT_START = CNT_BITS'(LATENCY - 1);

  state_t                  state_q, state_d;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic [PAYLOAD_BITS-1:0] payload_q, payload_d;
  logic                    ready_q, ready_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      payload_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    ready_d   = ready_q;
    commit_o  = 1'b0;
    abort_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          payload_d = payload_i;
          cnt_d     = CNT_START;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (!valid_i) begin
          abort_o = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end else begin
          commit_o = 1'b1;
          ready_d  = 1'b1;
          state_d  = RESPOND;
        end
      end
      RESPOND: begin
        if (!valid_i) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o   = ready_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/mem_responder.sv
// Multi-channel memory responder: 2^ADDR_BITS x DATA_BITS storage answering
// per-channel read and write requests after a fixed LATENCY.
//   clk, reset : clock, async active-high reset (storage is not cleared)
//   bus        : slave side of mem_responder_if (channels, preload, error)
// Storage access ordering on one edge: reads see the pre-edge contents,
// the preload write is applied first, then channel writes in ascending
// index so the highest channel wins.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int WP_BITS = ADDR_BITS + DATA_BITS;

  logic [DATA_BITS-1:0] storage [DEPTH];

  logic [NUM_CHANNELS-1:0]                rd_ready, rd_commit, rd_abort;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] rd_addr;
  logic [NUM_CHANNELS-1:0]                wr_ready, wr_commit, wr_abort;
  logic [NUM_CHANNELS-1:0][WP_BITS-1:0]   wr_payload;

  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic                                   protocol_error_q, protocol_error_d;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    mem_channel_fsm #(
      .LATENCY      (LATENCY),
      .PAYLOAD_BITS (ADDR_BITS)
    ) u_rd (
      .clk       (clk),
      .reset     (reset),
      .valid_i   (bus.mem_read_valid[c]),
      .payload_i (bus.mem_read_address[c]),
      .ready_o   (rd_ready[c]),
      .commit_o  (rd_commit[c]),
      .abort_o   (rd_abort[c]),
      .payload_o (rd_addr[c])
    );

    mem_channel_fsm #(
      .LATENCY      (LATENCY),
      .PAYLOAD_BITS (WP_BITS)
    ) u_wr (
      .clk       (clk),
      .reset     (reset),
      .valid_i   (bus.mem_write_valid[c]),
      .payload_i ({bus.mem_write_data[c], bus.mem_write_address[c]}),
      .ready_o   (wr_ready[c]),
      .commit_o  (wr_commit[c]),
      .abort_o   (wr_abort[c]),
      .payload_o (wr_payload[c])
    );
  end

  // Storage reads here use the pre-edge array contents, giving
  // read-before-write against any commit on the same edge.
  always_comb begin
    rd_data_d = rd_data_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (rd_commit[c]) rd_data_d[c] = storage[rd_addr[c]];
    end
  end

  always_comb begin
    protocol_error_d = protocol_error_q | (|rd_abort) | (|wr_abort);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q        <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      rd_data_q        <= rd_data_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  // Later assignments win: preload first, then channels low to high.
  always_ff @(posedge clk) begin
    if (bus.load_valid) storage[bus.load_address] <= bus.load_data;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wr_commit[c]) storage[wr_payload[c][ADDR_BITS-1:0]] <= wr_payload[c][WP_BITS-1:ADDR_BITS];
    end
  end

  assign bus.mem_read_ready  = rd_ready;
  assign bus.mem_read_data   = rd_data_q;
  assign bus.mem_write_ready = wr_ready;
  assign bus.protocol_error  = protocol_error_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int NCH = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NCH)) bus ();

  mem_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NCH), .LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit       is_wr;
    int       ch;
    bit [7:0] data;
    int       due;
  } exp_t;

  exp_t     sb[$];
  bit [7:0] ref_mem [256];
  int       n_checks = 0;
  int       n_pass   = 0;

  // per-round stimulus
  bit       r_en [NCH];
  bit [7:0] r_addr [NCH];
  bit       w_en [NCH];
  bit [7:0] w_addr [NCH];
  bit [7:0] w_data [NCH];
  bit       ld_en;
  bit [7:0] ld_addr, ld_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard on every rising ready.
  logic [NCH-1:0] prev_rr = '0, prev_wr = '0;
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 2; k++) begin
        bit rise;
        int idx;
        rise = (k == 0) ? (bus.mem_read_ready[c] && !prev_rr[c])
                        : (bus.mem_write_ready[c] && !prev_wr[c]);
        if (rise) begin
          idx = -1;
          foreach (sb[i]) if (idx < 0 && sb[i].ch == c && sb[i].is_wr == (k == 1)) idx = i;
          if (idx < 0) begin
            n_checks++;
            $display("FAIL unexpected_ready: ch%0d %s ready rose with nothing pending (cycle %0d)",
                     c, (k == 0) ? "read" : "write", cyc);
          end else begin
            chk($sformatf("ready_cycle ch%0d %s", c, (k == 0) ? "rd" : "wr"), 32'(cyc), 32'(sb[idx].due));
            if (k == 0) chk($sformatf("read_data ch%0d", c), 32'(bus.mem_read_data[c]), 32'(sb[idx].data));
            sb.delete(idx);
          end
        end
      end
    end
    prev_rr = bus.mem_read_ready;
    prev_wr = bus.mem_write_ready;
  end

  task automatic clear_round();
    for (int c = 0; c < NCH; c++) begin
      r_en[c] = 0; w_en[c] = 0; r_addr[c] = 0; w_addr[c] = 0; w_data[c] = 0;
    end
    ld_en = 0; ld_addr = 0; ld_data = 0;
  endtask

  task automatic load_word(input bit [7:0] a, input bit [7:0] d);
    @(negedge clk);
    bus.load_valid = 1; bus.load_address = a; bus.load_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    bus.load_valid = 0;
  endtask

  // All enabled requests start on one edge and therefore commit together.
  task automatic run_round();
    int   cap;
    exp_t e;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      bus.mem_read_valid[c]    = r_en[c];
      bus.mem_read_address[c]  = r_addr[c];
      bus.mem_write_valid[c]   = w_en[c];
      bus.mem_write_address[c] = w_addr[c];
      bus.mem_write_data[c]    = w_data[c];
    end
    cap = cyc + 1;
    // Reference: reads see memory before this round; preload then writes in
    // ascending channel order (last one wins).
    for (int c = 0; c < NCH; c++) begin
      if (r_en[c]) begin
        e.is_wr = 0; e.ch = c; e.data = ref_mem[r_addr[c]]; e.due = cap + LAT; sb.push_back(e);
      end
      if (w_en[c]) begin
        e.is_wr = 1; e.ch = c; e.data = 0; e.due = cap + LAT; sb.push_back(e);
      end
    end
    if (ld_en) ref_mem[ld_addr] = ld_data;
    for (int c = 0; c < NCH; c++) if (w_en[c]) ref_mem[w_addr[c]] = w_data[c];
    @(negedge clk);
    // Post-acceptance changes must be ignored.
    for (int c = 0; c < NCH; c++) begin
      bus.mem_read_address[c]  = 8'($urandom);
      bus.mem_write_address[c] = 8'($urandom);
      bus.mem_write_data[c]    = 8'($urandom);
    end
    while (cyc < cap + LAT - 1) @(negedge clk);
    if (ld_en) begin
      bus.load_valid = 1; bus.load_address = ld_addr; bus.load_data = ld_data;
    end
    @(negedge clk);
    bus.load_valid = 0;
    bus.mem_read_valid = '0;
    bus.mem_write_valid = '0;
    @(posedge clk); #1;
    chk("ready_drop_rd", 32'(bus.mem_read_ready), 32'(0));
    chk("ready_drop_wr", 32'(bus.mem_write_ready), 32'(0));
  endtask

  initial begin
    int t0;
    bus.mem_read_valid = '0; bus.mem_read_address = '0;
    bus.mem_write_valid = '0; bus.mem_write_address = '0; bus.mem_write_data = '0;
    bus.load_valid = 0; bus.load_address = '0; bus.load_data = '0;
    clear_round();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_read_ready", 32'(bus.mem_read_ready), 32'(0));
    chk("reset_write_ready", 32'(bus.mem_write_ready), 32'(0));
    chk("reset_read_data", 32'(bus.mem_read_data), 32'(0));
    chk("reset_protocol_error", 32'(bus.protocol_error), 32'(0));
    @(negedge clk);
    reset = 0;

    for (int a = 0; a < 256; a++) load_word(8'(a), 8'($urandom));

    // load + ch0 read
    load_word(8'h10, 8'h5A);
    clear_round(); r_en[0] = 1; r_addr[0] = 8'h10; run_round();

    // ch1 write, then ch2 read back
    clear_round(); w_en[1] = 1; w_addr[1] = 8'h20; w_data[1] = 8'hC3; run_round();
    clear_round(); r_en[2] = 1; r_addr[2] = 8'h20; run_round();

    // two writers, same address, same edge
    clear_round();
    w_en[0] = 1; w_addr[0] = 8'h30; w_data[0] = 8'h11;
    w_en[3] = 1; w_addr[3] = 8'h30; w_data[3] = 8'h22;
    run_round();
    clear_round(); r_en[1] = 1; r_addr[1] = 8'h30; run_round();

    // read-before-write
    load_word(8'h40, 8'h01);
    clear_round();
    w_en[0] = 1; w_addr[0] = 8'h40; w_data[0] = 8'h02;
    r_en[1] = 1; r_addr[1] = 8'h40;
    run_round();
    clear_round(); r_en[1] = 1; r_addr[1] = 8'h40; run_round();

    // channel write overrides preload on the same edge
    clear_round();
    w_en[2] = 1; w_addr[2] = 8'h45; w_data[2] = 8'hAB;
    ld_en = 1; ld_addr = 8'h45; ld_data = 8'hCD;
    run_round();
    clear_round(); r_en[3] = 1; r_addr[3] = 8'h45; run_round();

    // abort: valid dropped after one cycle
    @(negedge clk);
    bus.mem_write_valid[0] = 1; bus.mem_write_address[0] = 8'h50; bus.mem_write_data[0] = 8'h77;
    @(negedge clk);
    bus.mem_write_valid[0] = 0;
    @(posedge clk); #1;
    chk("abort_protocol_error", 32'(bus.protocol_error), 32'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_ready", 32'(bus.mem_write_ready), 32'(0));
    clear_round(); r_en[0] = 1; r_addr[0] = 8'h50; run_round();
    chk("protocol_error_sticky", 32'(bus.protocol_error), 32'(1));

    // reset during the WAIT of a write
    @(negedge clk);
    bus.mem_write_valid[1] = 1; bus.mem_write_address[1] = 8'h60; bus.mem_write_data[1] = 8'hEE;
    @(negedge clk);
    reset = 1;
    #1;
    chk("midreset_write_ready", 32'(bus.mem_write_ready), 32'(0));
    chk("midreset_protocol_error", 32'(bus.protocol_error), 32'(0));
    @(negedge clk);
    bus.mem_write_valid[1] = 0;
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("postreset_write_ready", 32'(bus.mem_write_ready), 32'(0));
    clear_round(); r_en[2] = 1; r_addr[2] = 8'h60; run_round();

    // randomized rounds over a small address window to provoke hazards
    for (int n = 0; n < 60; n++) begin
      clear_round();
      for (int c = 0; c < NCH; c++) begin
        r_en[c]   = 1'($urandom_range(0, 1));
        r_addr[c] = 8'(8'h80 + $urandom_range(0, 3));
        w_en[c]   = 1'($urandom_range(0, 1));
        w_addr[c] = 8'(8'h80 + $urandom_range(0, 3));
        w_data[c] = 8'($urandom);
      end
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = 8'(8'h80 + $urandom_range(0, 3));
      ld_data = 8'($urandom);
      run_round();
    end

    t0 = cyc;
    while (sb.size() != 0 && cyc < t0 + 50) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable multi-channel memory responder. It is the memory side of the valid/ready read/write channel protocol that the GPU top level drives toward external data memory.
- It stores 2^ADDR_BITS words of DATA_BITS and answers each channel's read and write requests after a fixed LATENCY.
- It is used as the data (or program) memory in system-level simulation and FPGA builds.
- A sideband load port preloads contents before kernel start.

Parameters:
- ADDR_BITS, 8, address width; storage depth is 2^ADDR_BITS.
- DATA_BITS, 8, word width.
- NUM_CHANNELS, 4, independent request channels. Each channel has one read FSM and one write FSM.
- LATENCY, 2, cycles from request acceptance to ready assertion; must be >= 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset. Clears control state only; storage is preserved.
- mem_read_valid  in  [NUM_CHANNELS]  per-channel read request.
- mem_read_address  in  [ADDR_BITS] x NUM_CHANNELS  read address.
- mem_read_ready  out  [NUM_CHANNELS]  read data valid / acknowledge.
- mem_read_data  out  [DATA_BITS] x NUM_CHANNELS  read data.
- mem_write_valid  in  [NUM_CHANNELS]  per-channel write request.
- mem_write_address  in  [ADDR_BITS] x NUM_CHANNELS  write address.
- mem_write_data  in  [DATA_BITS] x NUM_CHANNELS  write data.
- mem_write_ready  out  [NUM_CHANNELS]  write acknowledge.
- load_valid  in  1  preload strobe.
- load_address  in  ADDR_BITS  preload address.
- load_data  in  DATA_BITS  preload data.
- protocol_error  out  1  sticky flag: some requester dropped valid before ready.

Behaviour:
- Reset values:
  - All FSMs go to IDLE.
  - mem_read_ready=0, mem_write_ready=0, mem_read_data=0, protocol_error=0.
  - Storage is unchanged.
- FSM states per read or write channel: IDLE, WAIT, RESPOND.
- IDLE:
  - valid sampled 1 at edge t: capture address (and write data), counter <= LATENCY-1, go to WAIT.
  - Later changes to address or data are ignored for this transaction.
- WAIT:
  - valid=1, counter != 0: decrement.
  - valid=1, counter == 0:
    - Read: mem_read_data <= storage[addr].
    - Write: storage[addr] <= data.
    - ready <= 1, go to RESPOND.
  - Net effect: ready rises at edge t+LATENCY.
  - valid=0 (abort): go to IDLE, no commit, ready stays 0, protocol_error <= 1.
- RESPOND:
  - ready and data are held while valid=1; no new transaction starts.
  - valid sampled 0: ready <= 0, go to IDLE.
  - A new request is accepted no earlier than the following edge.
- Read and write FSMs of the same channel are independent and may overlap.
- Same-edge hazards:
  - A read completing on the same edge as a write commit to the same address returns the OLD value (read-before-write).
  - Multiple write commits to one address on one edge: the highest channel index wins.
  - Channel write commits override a load_valid write to the same address.
- load_valid: storage[load_address] <= load_data on that edge, regardless of FSM states.
- protocol_error clears only on reset.
- Reset mid-transaction: pending writes in WAIT are not committed; a later request restarts from IDLE.
- Counter width is $clog2(LATENCY+1) with no wrap; the counter saturates at 0.

Decomposition:
- Package mem_responder_pkg:
  - typedef enum state_t {IDLE, WAIT, RESPOND} (2-bit encoding).
  - Localparam helper for the counter width.
- Sub-module mem_channel_fsm:
  - Parameterized by LATENCY.
  - Outputs a commit strobe, captured address/data, and ready.
  - Instantiated 2*NUM_CHANNELS times.
- The top level owns the storage array and resolves commit priority and read-before-write.

Test Plan:
- Load 0x10<-0x5A, then ch0 read 0x10 with LATENCY=2, valid at edge 0 → ready=1 and data=0x5A at edge 2. Drop valid → ready=0 next edge.
- ch1 write 0x20<-0xC3 → write_ready at edge 2. Then ch2 read 0x20 → 0xC3.
- ch0 and ch3 both write 0x30 with 0x11 and 0x22, committing on the same edge → read 0x30 returns 0x22.
- Storage 0x40=0x01. A ch0 write of 0x02 and a ch1 read of 0x40 commit on the same edge → read returns 0x01; a subsequent read returns 0x02.
- ch0 write 0x50<-0x77 with valid dropped after 1 cycle → no ready, protocol_error=1, 0x50 unchanged.
- Assert reset during WAIT of a write to 0x60 → ready stays 0, 0x60 unchanged, protocol_error=0. A fresh read after reset completes normally.
